// File: rtl/nor_truth_scan_if.sv
// Handshake and gate-under-test signals for the truth-table scanner.
interface nor_truth_scan_if;
  logic       start;
  logic [2:0] op;
  logic       in0;
  logic       in1;
  logic       gate_out;
  logic       busy;
  logic       done;
  logic [3:0] truth_table;
  logic       pass;

  // Scanner side
  modport slave (
    input  start,
    input  op,
    input  gate_out,
    output in0,
    output in1,
    output busy,
    output done,
    output truth_table,
    output pass
  );

  // Requester / gate side
  modport master (
    output start,
    output op,
    output gate_out,
    input  in0,
    input  in1,
    input  busy,
    input  done,
    input  truth_table,
    input  pass
  );
endinterface

// File: rtl/nor_truth_scan.sv
// Drives all four input vectors into a 2-input gate, captures its truth table
// and compares it against the table expected for the requested gate type.
module nor_truth_scan #(
  parameter int unsigned SETTLE = 1  // cycles per vector, 1..15
) (
  input  logic              clk,
  input  logic              reset,
  nor_truth_scan_if.slave   bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] table_q, table_d;
  logic       pass_q, pass_d;

  logic       sample;
  logic [3:0] table_upd;

  // Reference truth tables; reserved ops map to 0 and are rejected separately.
  function automatic logic [3:0] exp_table(input logic [2:0] op);
    case (op)
      3'd0:    exp_table = 4'b1000;  // AND
      3'd1:    exp_table = 4'b1110;  // OR
      3'd2:    exp_table = 4'b0111;  // NAND
      3'd3:    exp_table = 4'b0001;  // NOR
      3'd4:    exp_table = 4'b0110;  // XOR
      3'd5:    exp_table = 4'b1001;  // XNOR
      default: exp_table = 4'b0000;
    endcase
  endfunction

  // Next-state logic for the FSM and scan datapath.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    table_d   = table_q;
    pass_d    = pass_q;
    sample    = (state_q == StDrive) && (cnt_q == 4'(SETTLE - 1));
    table_upd = table_q;
    table_upd[idx_q] = bus.gate_out;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StDrive;
          op_d    = bus.op;
          idx_d   = 2'd0;
          cnt_d   = 4'd0;
          table_d = 4'd0;
          pass_d  = 1'b0;
        end
      end
      StDrive: begin
        if (sample) begin
          cnt_d   = 4'd0;
          idx_d   = idx_q + 2'd1;
          table_d = table_upd;
          if (idx_q == 2'd3) begin
            state_d = StDone;
            // Last bit is folded in here so pass sees the complete table.
            pass_d  = (op_q < 3'd6) && (table_upd == exp_table(op_q));
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; reset aborts any scan in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= 3'd0;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      table_q <= 4'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      pass_q  <= pass_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.busy        = (state_q == StDrive);
    bus.done        = (state_q == StDone);
    bus.in0         = (state_q == StDrive) ? idx_q[1] : 1'b0;
    bus.in1         = (state_q == StDrive) ? idx_q[0] : 1'b0;
    bus.truth_table = table_q;
    bus.pass        = pass_q;
  end

endmodule

// File: tb/tb_nor_truth_scan.sv
// Scoreboard bench: stimulus pushes expected scan results, monitors pop them on done.
module tb_nor_truth_scan;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   model_a = 3;
  int   model_b = 4;

  typedef struct {
    logic [3:0] tbl;
    logic       pass;
    int         cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  nor_truth_scan_if bus_a ();
  nor_truth_scan_if bus_b ();

  nor_truth_scan #(.SETTLE(1)) dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a)
  );

  nor_truth_scan #(.SETTLE(3)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR
  function automatic logic gate_fn(input int m, input logic a, input logic b);
    case (m)
      0:       gate_fn = a & b;
      1:       gate_fn = a | b;
      2:       gate_fn = ~(a & b);
      3:       gate_fn = ~(a | b);
      4:       gate_fn = a ^ b;
      default: gate_fn = ~(a ^ b);
    endcase
  endfunction

  assign bus_a.gate_out = gate_fn(model_a, bus_a.in0, bus_a.in1);
  assign bus_b.gate_out = gate_fn(model_b, bus_b.in0, bus_b.in1);

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for SETTLE=1 instance
  always @(negedge clk) begin
    if (bus_a.done === 1'b1) begin
      if (q_a.size() == 0) begin
        chk("A unexpected done", 1, 0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("A table", int'(bus_a.truth_table), int'(e.tbl));
        chk("A pass", int'(bus_a.pass), int'(e.pass));
        chk("A done cycle", cyc, e.cyc);
      end
    end
  end

  // Monitor for SETTLE=3 instance
  always @(negedge clk) begin
    if (bus_b.done === 1'b1) begin
      if (q_b.size() == 0) begin
        chk("B unexpected done", 1, 0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("B table", int'(bus_b.truth_table), int'(e.tbl));
        chk("B pass", int'(bus_b.pass), int'(e.pass));
        chk("B done cycle", cyc, e.cyc);
      end
    end
  end

  // One full scan on instance A; done expected 5 cycles after the issue negedge.
  task automatic scan_a(input logic [2:0] op, input int model, input logic [3:0] tbl,
                        input logic pass);
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.op    = op;
    model_a     = model;
    q_a.push_back('{tbl: tbl, pass: pass, cyc: cyc + 5});
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.start = 1'b0;
    bus_a.op    = 3'd0;
    bus_b.start = 1'b0;
    bus_b.op    = 3'd0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset state
    chk("reset busy", int'(bus_a.busy), 0);
    chk("reset done", int'(bus_a.done), 0);
    chk("reset in", int'({bus_a.in0, bus_a.in1}), 0);
    chk("reset table", int'(bus_a.truth_table), 0);
    chk("reset pass", int'(bus_a.pass), 0);

    // NOR scan with vector sequence check
    bus_a.start = 1'b1;
    bus_a.op    = 3'd3;
    model_a     = 3;
    q_a.push_back('{tbl: 4'b0001, pass: 1'b1, cyc: cyc + 5});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) bus_a.start = 1'b0;
      chk("A vector", int'({bus_a.in0, bus_a.in1}), k);
      chk("A busy", int'(bus_a.busy), 1);
    end
    repeat (3) @(negedge clk);

    // Wrong gate, then right gate
    scan_a(3'd0, 3, 4'b0001, 1'b0);
    scan_a(3'd0, 0, 4'b1000, 1'b1);

    // Start held through the scan, op changed mid-scan
    @(negedge clk);
    bus_a.start = 1'b1;
    bus_a.op    = 3'd3;
    model_a     = 3;
    q_a.push_back('{tbl: 4'b0001, pass: 1'b1, cyc: cyc + 5});
    repeat (2) @(negedge clk);
    bus_a.op = 3'd1;
    repeat (3) @(negedge clk);
    chk("A held-start done", int'(bus_a.done), 1);
    bus_a.start = 1'b0;
    @(negedge clk);
    chk("A no requeue busy", int'(bus_a.busy), 0);
    repeat (3) @(negedge clk);

    // Reset during idx=2
    bus_a.start = 1'b1;
    bus_a.op    = 3'd3;
    model_a     = 3;
    @(negedge clk);
    bus_a.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("A idx2 vector", int'({bus_a.in0, bus_a.in1}), 2);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    chk("abort busy", int'(bus_a.busy), 0);
    chk("abort table", int'(bus_a.truth_table), 0);
    chk("abort in", int'({bus_a.in0, bus_a.in1}), 0);
    chk("abort done", int'(bus_a.done), 0);
    chk("abort pass", int'(bus_a.pass), 0);
    repeat (6) @(negedge clk);
    scan_a(3'd3, 3, 4'b0001, 1'b1);

    // Reserved op and XNOR
    scan_a(3'd6, 3, 4'b0001, 1'b0);
    scan_a(3'd5, 5, 4'b1001, 1'b1);

    // SETTLE=3 XOR scan, each vector held 3 cycles
    @(negedge clk);
    bus_b.start = 1'b1;
    bus_b.op    = 3'd4;
    model_b     = 4;
    q_b.push_back('{tbl: 4'b0110, pass: 1'b1, cyc: cyc + 13});
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) bus_b.start = 1'b0;
      chk("B vector", int'({bus_b.in0, bus_b.in1}), k / 3);
    end
    repeat (4) @(negedge clk);

    chk("A pending expectations", q_a.size(), 0);
    chk("B pending expectations", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nor_truth_scan.md
NOR_TRUTH_SCAN -- requirements
Module: nor_truth_scan

Interface
REQ-001 Parameter: SETTLE, default 1, is the number of cycles each input vector is driven before gate_out is sampled; legal range is 1..15.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  scan request, sampled only in IDLE.
REQ-006 Port: op  input  3  expected gate type, captured when start is accepted.
REQ-007 Port: in0  output  1  first operand driven to the downstream gate under test.
REQ-008 Port: in1  output  1  second operand driven to the downstream gate under test.
REQ-009 Port: gate_out  input  1  result returned by the gate under test.
REQ-010 Port: busy  output  1  high in DRIVE state.
REQ-011 Port: done  output  1  one-cycle pulse marking scan completion.
REQ-012 Port: table  output  4  captured truth table; bit i = gate_out for {in0,in1} = i.
REQ-013 Port: pass  output  1  high when table equals the expected table for captured op.

Function
REQ-014 The FSM SHALL have the states IDLE, DRIVE and DONE, encoded in 2 bits.
REQ-015 In IDLE, start=1 SHALL move the FSM to DRIVE on the next edge, with these actions: capture op, set vector index idx=0, set settle count cnt=0, clear table, clear pass.
REQ-016 In DRIVE, the outputs SHALL be {in0,in1}=idx (in0 = MSB); in IDLE and DONE, in0 and in1 SHALL be 0.
REQ-017 In DRIVE, cnt SHALL increment each cycle; on the edge where cnt==SETTLE-1, table[idx] SHALL load gate_out, cnt SHALL return to 0 and idx SHALL increment (2-bit).
REQ-018 The sampling edge for idx==3 SHALL move the FSM to DONE; idx wraps to 0.
REQ-019 DONE SHALL last exactly one cycle (done=1), then return to IDLE.
REQ-020 pass SHALL be computed on the DRIVE->DONE edge and held, together with table, until the next accepted start or reset.
REQ-021 Expected tables by op: 0 AND=1000, 1 OR=1110, 2 NAND=0111, 3 NOR=0001, 4 XOR=0110, 5 XNOR=1001.
REQ-022 op 6 and op 7 SHALL be reserved: pass=0 regardless of table.
REQ-023 start in DRIVE or DONE SHALL be ignored; it is not queued.
REQ-024 Latency: for a start accepted at edge E0, done SHALL be high in the cycle following edge E0+4*SETTLE.
REQ-025 A change of op after capture SHALL NOT affect the scan in progress.

Reset
REQ-026 When reset=1 at an edge, the block SHALL enter IDLE and clear idx, cnt, table, pass, done, busy, in0 and in1 to 0, overriding start.
REQ-027 A reset asserted mid-scan SHALL abort the scan; no done pulse and no partial table SHALL be visible afterwards.

Verification
REQ-028 Scenario: SETTLE=1, op=3, NOR model on gate_out, start pulse -> in0/in1 sequence 00,01,10,11 over 4 cycles; done high 5th cycle; table=0001; pass=1.
REQ-029 Scenario: op=0 with NOR model -> table=0001, pass=0; then op=0 with AND model -> table=1000, pass=1.
REQ-030 Scenario: SETTLE=3, op=4, XOR model -> each vector held 3 cycles; done 13 cycles after start edge; table=0110; pass=1.
REQ-031 Scenario: start held high throughout the scan and op changed to 1 mid-scan -> exactly one done pulse; the result uses the captured op; a new scan starts only after return to IDLE.
REQ-032 Scenario: reset asserted during vector idx=2 -> next cycle busy=0, table=0000, in0=in1=0, no done pulse; a later start produces a correct full scan.
REQ-033 Scenario: op=6 with any model -> pass=0; op=5 with XNOR model -> table=1001, pass=1.
